// File: rtl/load_store_buffer_pkg.sv
// Shared widths, op encodings and entry layout for the load/store buffer.
package load_store_buffer_pkg;

  localparam int XLEN             = 32;
  localparam int ROB_SIZE_WIDTH   = 4;
  // One extra bit over the ROB id so that all-ones never aliases a real id.
  localparam int DEPENDENCY_WIDTH = ROB_SIZE_WIDTH + 1;
  localparam int INST_OP_WIDTH    = 6;
  localparam int LSB_SIZE_WIDTH   = 3;
  localparam int LSB_SIZE         = 1 << LSB_SIZE_WIDTH;

  localparam logic [DEPENDENCY_WIDTH-1:0] NO_DEP  = '1;
  localparam logic [XLEN-1:0]             IO_BASE = 32'h0003_0000;

  localparam logic [INST_OP_WIDTH-1:0] OP_NOP = 6'd0;
  localparam logic [INST_OP_WIDTH-1:0] OP_LB  = 6'd1;
  localparam logic [INST_OP_WIDTH-1:0] OP_LH  = 6'd2;
  localparam logic [INST_OP_WIDTH-1:0] OP_LW  = 6'd3;
  localparam logic [INST_OP_WIDTH-1:0] OP_LBU = 6'd4;
  localparam logic [INST_OP_WIDTH-1:0] OP_LHU = 6'd5;
  localparam logic [INST_OP_WIDTH-1:0] OP_SB  = 6'd6;
  localparam logic [INST_OP_WIDTH-1:0] OP_SH  = 6'd7;
  localparam logic [INST_OP_WIDTH-1:0] OP_SW  = 6'd8;
  localparam logic [INST_OP_WIDTH-1:0] OP_ADD = 6'd9;

  typedef struct packed {
    logic [INST_OP_WIDTH-1:0]    op;
    logic [ROB_SIZE_WIDTH-1:0]   id;
    logic [XLEN-1:0]             imm;
    logic [DEPENDENCY_WIDTH-1:0] q1;
    logic [XLEN-1:0]             v1;
    logic [DEPENDENCY_WIDTH-1:0] q2;
    logic [XLEN-1:0]             v2;
  } lsb_entry_t;

  localparam lsb_entry_t ENTRY_RESET = '{op: '0, id: '0, imm: '0,
                                         q1: NO_DEP, v1: '0,
                                         q2: NO_DEP, v2: '0};

  function automatic logic is_load(input logic [INST_OP_WIDTH-1:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(input logic [INST_OP_WIDTH-1:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

endpackage

// File: rtl/load_store_buffer_if.sv
// Decoder, ROB, ALU and memory-controller signals seen by the load/store buffer.
interface load_store_buffer_if;
  import load_store_buffer_pkg::*;

  logic                        rdy;
  logic                        flush;
  logic                        stall;
  logic                        dec_ready;
  logic [INST_OP_WIDTH-1:0]    dec_op;
  logic [XLEN-1:0]             dec_imm;
  logic [DEPENDENCY_WIDTH-1:0] rf_dep1;
  logic [DEPENDENCY_WIDTH-1:0] rf_dep2;
  logic [XLEN-1:0]             rf_val1;
  logic [XLEN-1:0]             rf_val2;
  logic                        rob_Q1_ready;
  logic [XLEN-1:0]             rob_Q1_val;
  logic                        rob_Q2_ready;
  logic [XLEN-1:0]             rob_Q2_val;
  logic [ROB_SIZE_WIDTH-1:0]   rob_tail_id;
  logic [ROB_SIZE_WIDTH-1:0]   rob_head_id;
  logic                        alu_ready;
  logic [XLEN-1:0]             alu_res;
  logic [ROB_SIZE_WIDTH-1:0]   alu_id;
  logic                        mem_busy;
  logic                        mem_data_ready;
  logic [XLEN-1:0]             mem_data;
  logic [ROB_SIZE_WIDTH-1:0]   mem_id;

  logic                        lsb_full;
  logic                        lsb_empty;
  logic [INST_OP_WIDTH-1:0]    lsb_front_op;
  logic [ROB_SIZE_WIDTH-1:0]   lsb_front_id;
  logic [DEPENDENCY_WIDTH-1:0] lsb_front_Q1;
  logic [XLEN-1:0]             lsb_front_V1;
  logic [DEPENDENCY_WIDTH-1:0] lsb_front_Q2;
  logic [XLEN-1:0]             lsb_front_V2;
  logic                        lsb_mem_enable;
  logic [INST_OP_WIDTH-1:0]    lsb_mem_op;
  logic [XLEN-1:0]             lsb_mem_addr;
  logic [ROB_SIZE_WIDTH-1:0]   lsb_mem_id;

  modport master (
    output rdy, flush, stall, dec_ready, dec_op, dec_imm,
           rf_dep1, rf_dep2, rf_val1, rf_val2,
           rob_Q1_ready, rob_Q1_val, rob_Q2_ready, rob_Q2_val,
           rob_tail_id, rob_head_id, alu_ready, alu_res, alu_id,
           mem_busy, mem_data_ready, mem_data, mem_id,
    input  lsb_full, lsb_empty, lsb_front_op, lsb_front_id,
           lsb_front_Q1, lsb_front_V1, lsb_front_Q2, lsb_front_V2,
           lsb_mem_enable, lsb_mem_op, lsb_mem_addr, lsb_mem_id
  );

  modport slave (
    input  rdy, flush, stall, dec_ready, dec_op, dec_imm,
           rf_dep1, rf_dep2, rf_val1, rf_val2,
           rob_Q1_ready, rob_Q1_val, rob_Q2_ready, rob_Q2_val,
           rob_tail_id, rob_head_id, alu_ready, alu_res, alu_id,
           mem_busy, mem_data_ready, mem_data, mem_id,
    output lsb_full, lsb_empty, lsb_front_op, lsb_front_id,
           lsb_front_Q1, lsb_front_V1, lsb_front_Q2, lsb_front_V2,
           lsb_mem_enable, lsb_mem_op, lsb_mem_addr, lsb_mem_id
  );

endinterface

// File: rtl/load_store_buffer_operand_wakeup.sv
// One operand slot: replaces a pending tag with a matching ALU or memory broadcast.
module lsb_operand_wakeup
  import load_store_buffer_pkg::*;
(
  input  logic [DEPENDENCY_WIDTH-1:0] q_i,
  input  logic [XLEN-1:0]             v_i,
  input  logic                        alu_ready_i,
  input  logic [XLEN-1:0]             alu_res_i,
  input  logic [ROB_SIZE_WIDTH-1:0]   alu_id_i,
  input  logic                        mem_ready_i,
  input  logic [XLEN-1:0]             mem_data_i,
  input  logic [ROB_SIZE_WIDTH-1:0]   mem_id_i,
  output logic [DEPENDENCY_WIDTH-1:0] q_o,
  output logic [XLEN-1:0]             v_o
);

  // A resolved operand (all-ones tag) can never match: broadcast ids are zero-extended.
  always_comb begin
    q_o = q_i;
    v_o = v_i;
    if (alu_ready_i && (q_i == DEPENDENCY_WIDTH'(alu_id_i))) begin
      q_o = NO_DEP;
      v_o = alu_res_i;
    end else if (mem_ready_i && (q_i == DEPENDENCY_WIDTH'(mem_id_i))) begin
      q_o = NO_DEP;
      v_o = mem_data_i;
    end
  end

endmodule

// File: rtl/load_store_buffer.sv
// In-order load/store queue: captures operands at dispatch, wakes them from
// broadcasts, pops ready stores and issues loads strictly from the front.
module load_store_buffer (
  input logic                clk,
  input logic                rst,
  load_store_buffer_if.slave bus
);
  import load_store_buffer_pkg::*;

  typedef logic [LSB_SIZE_WIDTH-1:0] ptr_t;

  lsb_entry_t                  ent_q [LSB_SIZE];
  lsb_entry_t                  ent_d [LSB_SIZE];
  ptr_t                        head_q, head_d, tail_q, tail_d;
  logic                        mem_en_q, mem_en_d;
  logic [INST_OP_WIDTH-1:0]    mem_op_q, mem_op_d;
  logic [XLEN-1:0]             mem_addr_q, mem_addr_d;
  logic [ROB_SIZE_WIDTH-1:0]   mem_id_q, mem_id_d;

  logic [DEPENDENCY_WIDTH-1:0] wk_q1 [LSB_SIZE];
  logic [DEPENDENCY_WIDTH-1:0] wk_q2 [LSB_SIZE];
  logic [XLEN-1:0]             wk_v1 [LSB_SIZE];
  logic [XLEN-1:0]             wk_v2 [LSB_SIZE];

  logic [DEPENDENCY_WIDTH-1:0] pre_q1, pre_q2, cap_q1, cap_q2;
  logic [XLEN-1:0]             pre_v1, pre_v2, cap_v1, cap_v2;

  lsb_entry_t                  front, new_ent;
  logic [XLEN-1:0]             front_addr;
  logic                        empty, full, store_pop, load_issue, pop, enq;

  // Per-entry wakeup of both operands from this cycle's broadcasts.
  for (genvar g = 0; g < LSB_SIZE; g++) begin : g_ent
    lsb_operand_wakeup u_wk1 (
      .q_i(ent_q[g].q1), .v_i(ent_q[g].v1),
      .alu_ready_i(bus.alu_ready), .alu_res_i(bus.alu_res), .alu_id_i(bus.alu_id),
      .mem_ready_i(bus.mem_data_ready), .mem_data_i(bus.mem_data), .mem_id_i(bus.mem_id),
      .q_o(wk_q1[g]), .v_o(wk_v1[g])
    );
    lsb_operand_wakeup u_wk2 (
      .q_i(ent_q[g].q2), .v_i(ent_q[g].v2),
      .alu_ready_i(bus.alu_ready), .alu_res_i(bus.alu_res), .alu_id_i(bus.alu_id),
      .mem_ready_i(bus.mem_data_ready), .mem_data_i(bus.mem_data), .mem_id_i(bus.mem_id),
      .q_o(wk_q2[g]), .v_o(wk_v2[g])
    );
  end

  // Dispatch capture, first two priorities: register file, then ROB bypass.
  always_comb begin
    pre_q1 = bus.rf_dep1;
    pre_v1 = '0;
    if (bus.rf_dep1 == NO_DEP) begin
      pre_v1 = bus.rf_val1;
    end else if (bus.rob_Q1_ready) begin
      pre_q1 = NO_DEP;
      pre_v1 = bus.rob_Q1_val;
    end
    pre_q2 = bus.rf_dep2;
    pre_v2 = '0;
    if (bus.rf_dep2 == NO_DEP) begin
      pre_v2 = bus.rf_val2;
    end else if (bus.rob_Q2_ready) begin
      pre_q2 = NO_DEP;
      pre_v2 = bus.rob_Q2_val;
    end
  end

  // Same-cycle broadcasts close the remaining dispatch-time dependencies.
  lsb_operand_wakeup u_cap1 (
    .q_i(pre_q1), .v_i(pre_v1),
    .alu_ready_i(bus.alu_ready), .alu_res_i(bus.alu_res), .alu_id_i(bus.alu_id),
    .mem_ready_i(bus.mem_data_ready), .mem_data_i(bus.mem_data), .mem_id_i(bus.mem_id),
    .q_o(cap_q1), .v_o(cap_v1)
  );
  lsb_operand_wakeup u_cap2 (
    .q_i(pre_q2), .v_i(pre_v2),
    .alu_ready_i(bus.alu_ready), .alu_res_i(bus.alu_res), .alu_id_i(bus.alu_id),
    .mem_ready_i(bus.mem_data_ready), .mem_data_i(bus.mem_data), .mem_id_i(bus.mem_id),
    .q_o(cap_q2), .v_o(cap_v2)
  );

  // Front decode, pop/issue/enqueue decisions and the new entry image.
  always_comb begin
    front      = ent_q[head_q];
    front_addr = front.v1 + front.imm;
    empty      = (head_q == tail_q);
    full       = (head_q == (tail_q + ptr_t'(1)));
    store_pop  = !empty && is_store(front.op) && (front.q1 == NO_DEP) && (front.q2 == NO_DEP);
    // I/O reads must not be speculative, so they wait until they are the oldest in the ROB.
    load_issue = !empty && is_load(front.op) && (front.q1 == NO_DEP) && !bus.mem_busy &&
                 ((front_addr < IO_BASE) || (front.id == bus.rob_head_id));
    pop        = store_pop || load_issue;
    // A pop frees the head slot in the same cycle, so a full queue still accepts then.
    enq        = !bus.stall && bus.dec_ready && (is_load(bus.dec_op) || is_store(bus.dec_op)) &&
                 (!full || pop);
    new_ent     = '{op: bus.dec_op, id: bus.rob_tail_id, imm: bus.dec_imm,
                    q1: cap_q1, v1: cap_v1, q2: cap_q2, v2: cap_v2};
    if (is_load(bus.dec_op)) begin
      new_ent.q2 = NO_DEP;
      new_ent.v2 = '0;
    end
  end

  // Next-state for entries, pointers and the registered load request.
  always_comb begin
    for (int i = 0; i < LSB_SIZE; i++) begin
      ent_d[i]    = ent_q[i];
      ent_d[i].q1 = wk_q1[i];
      ent_d[i].v1 = wk_v1[i];
      ent_d[i].q2 = wk_q2[i];
      ent_d[i].v2 = wk_v2[i];
    end
    if (enq) ent_d[tail_q] = new_ent;
    head_d     = head_q + ptr_t'(pop);
    tail_d     = tail_q + ptr_t'(enq);
    mem_en_d   = load_issue;
    mem_op_d   = mem_op_q;
    mem_addr_d = mem_addr_q;
    mem_id_d   = mem_id_q;
    if (load_issue) begin
      mem_op_d   = front.op;
      mem_addr_d = front_addr;
      mem_id_d   = front.id;
    end
  end

  // State update; rdy low freezes everything including reset, reset beats flush.
  always_ff @(posedge clk) begin
    if (bus.rdy) begin
      if (rst) begin
        head_q     <= '0;
        tail_q     <= '0;
        mem_en_q   <= 1'b0;
        mem_op_q   <= '0;
        mem_addr_q <= '0;
        mem_id_q   <= '0;
        for (int i = 0; i < LSB_SIZE; i++) ent_q[i] <= ENTRY_RESET;
      end else if (bus.flush) begin
        head_q   <= '0;
        tail_q   <= '0;
        mem_en_q <= 1'b0;
      end else begin
        head_q     <= head_d;
        tail_q     <= tail_d;
        mem_en_q   <= mem_en_d;
        mem_op_q   <= mem_op_d;
        mem_addr_q <= mem_addr_d;
        mem_id_q   <= mem_id_d;
        for (int i = 0; i < LSB_SIZE; i++) ent_q[i] <= ent_d[i];
      end
    end
  end

  assign bus.lsb_full       = full;
  assign bus.lsb_empty      = empty;
  assign bus.lsb_front_op   = front.op;
  assign bus.lsb_front_id   = front.id;
  assign bus.lsb_front_Q1   = front.q1;
  assign bus.lsb_front_V1   = front_addr;
  assign bus.lsb_front_Q2   = front.q2;
  assign bus.lsb_front_V2   = front.v2;
  assign bus.lsb_mem_enable = mem_en_q;
  assign bus.lsb_mem_op     = mem_op_q;
  assign bus.lsb_mem_addr   = mem_addr_q;
  assign bus.lsb_mem_id     = mem_id_q;

endmodule

// File: tb/tb_load_store_buffer.sv
// Bench for load_store_buffer: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a queue-based reference model.
module tb_load_store_buffer;
  import load_store_buffer_pkg::*;

  localparam logic [4:0] ND = 5'h1f;

  typedef struct {
    logic [5:0]  op;
    logic [3:0]  id;
    logic [31:0] imm;
    logic [4:0]  q1;
    logic [31:0] v1;
    logic [4:0]  q2;
    logic [31:0] v2;
  } ment_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  load_store_buffer_if bif();
  load_store_buffer dut (.clk(clk), .rst(rst), .bus(bif.slave));

  always #5 clk = ~clk;

  // Reference model state: program-ordered queue and the last load request.
  ment_t       mq[$];
  logic        m_en;
  logic [5:0]  m_op;
  logic [31:0] m_addr;
  logic [3:0]  m_id;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit m_is_ld(input logic [5:0] op);
    return op == OP_LB || op == OP_LH || op == OP_LW || op == OP_LBU || op == OP_LHU;
  endfunction

  function automatic bit m_is_st(input logic [5:0] op);
    return op == OP_SB || op == OP_SH || op == OP_SW;
  endfunction

  // Resolve a pending tag against this cycle's broadcasts (ALU first).
  task automatic wake(inout logic [4:0] q, inout logic [31:0] v);
    if (bif.alu_ready && q == {1'b0, bif.alu_id}) begin
      q = ND; v = bif.alu_res;
    end else if (bif.mem_data_ready && q == {1'b0, bif.mem_id}) begin
      q = ND; v = bif.mem_data;
    end
  endtask

  task automatic capture(input logic [4:0] dep, input logic [31:0] rfv, input logic rr,
                         input logic [31:0] rv, output logic [4:0] q, output logic [31:0] v);
    if (dep == ND) begin q = ND; v = rfv; end
    else if (rr) begin q = ND; v = rv; end
    else begin
      q = dep; v = 32'd0;
      wake(q, v);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_en = 1'b0; m_op = '0; m_addr = '0; m_id = '0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    ment_t e;
    logic [4:0] tq; logic [31:0] tv;
    bit pop, iss, enq;
    logic [31:0] a;
    if (!bif.rdy) return;
    if (rst) begin model_reset(); return; end
    if (bif.flush) begin mq.delete(); m_en = 1'b0; return; end
    pop = 0; iss = 0; a = '0;
    if (mq.size() > 0) begin
      a = mq[0].v1 + mq[0].imm;
      if (m_is_st(mq[0].op) && mq[0].q1 == ND && mq[0].q2 == ND) pop = 1;
      if (m_is_ld(mq[0].op) && mq[0].q1 == ND && !bif.mem_busy &&
          (a < 32'h30000 || mq[0].id == bif.rob_head_id)) begin
        pop = 1; iss = 1;
      end
    end
    m_en = iss;
    if (iss) begin m_op = mq[0].op; m_addr = a; m_id = mq[0].id; end
    foreach (mq[i]) begin
      e = mq[i];
      tq = e.q1; tv = e.v1; wake(tq, tv); e.q1 = tq; e.v1 = tv;
      tq = e.q2; tv = e.v2; wake(tq, tv); e.q2 = tq; e.v2 = tv;
      mq[i] = e;
    end
    enq = bif.dec_ready && !bif.stall && (m_is_ld(bif.dec_op) || m_is_st(bif.dec_op)) &&
          (mq.size() < 7 || pop);
    if (enq) begin
      e.op = bif.dec_op; e.id = bif.rob_tail_id; e.imm = bif.dec_imm;
      capture(bif.rf_dep1, bif.rf_val1, bif.rob_Q1_ready, bif.rob_Q1_val, tq, tv);
      e.q1 = tq; e.v1 = tv;
      capture(bif.rf_dep2, bif.rf_val2, bif.rob_Q2_ready, bif.rob_Q2_val, tq, tv);
      e.q2 = tq; e.v2 = tv;
      if (m_is_ld(e.op)) begin e.q2 = ND; e.v2 = 32'd0; end
    end
    if (pop) void'(mq.pop_front());
    if (enq) mq.push_back(e);
  endtask

  task automatic compare_outputs();
    check_val("empty", bif.lsb_empty, mq.size() == 0);
    check_val("full", bif.lsb_full, mq.size() == 7);
    check_val("mem_enable", bif.lsb_mem_enable, m_en);
    check_val("mem_op", bif.lsb_mem_op, m_op);
    check_val("mem_addr", bif.lsb_mem_addr, m_addr);
    check_val("mem_id", bif.lsb_mem_id, m_id);
    if (mq.size() > 0) begin
      check_val("front_op", bif.lsb_front_op, mq[0].op);
      check_val("front_id", bif.lsb_front_id, mq[0].id);
      check_val("front_Q1", bif.lsb_front_Q1, mq[0].q1);
      check_val("front_Q2", bif.lsb_front_Q2, mq[0].q2);
      if (mq[0].q1 == ND) check_val("front_V1", bif.lsb_front_V1, mq[0].v1 + mq[0].imm);
      if (mq[0].q2 == ND) check_val("front_V2", bif.lsb_front_V2, mq[0].v2);
    end
  endtask

  // Called just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic tick();
    #1;
    compare_outputs();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_idle();
    bif.rdy = 1'b1; bif.flush = 1'b0; bif.stall = 1'b0;
    bif.dec_ready = 1'b0; bif.dec_op = OP_NOP; bif.dec_imm = '0;
    bif.rf_dep1 = ND; bif.rf_dep2 = ND; bif.rf_val1 = '0; bif.rf_val2 = '0;
    bif.rob_Q1_ready = 1'b0; bif.rob_Q1_val = '0; bif.rob_Q2_ready = 1'b0; bif.rob_Q2_val = '0;
    bif.rob_tail_id = '0;
    bif.alu_ready = 1'b0; bif.alu_res = '0; bif.alu_id = '0;
    bif.mem_busy = 1'b0; bif.mem_data_ready = 1'b0; bif.mem_data = '0; bif.mem_id = '0;
  endtask

  task automatic disp(input logic [5:0] op, input logic [31:0] imm,
                      input logic [4:0] d1, input logic [31:0] v1,
                      input logic [4:0] d2, input logic [31:0] v2, input logic [3:0] id);
    bif.dec_ready = 1'b1; bif.stall = 1'b0; bif.dec_op = op; bif.dec_imm = imm;
    bif.rf_dep1 = d1; bif.rf_val1 = v1; bif.rf_dep2 = d2; bif.rf_val2 = v2;
    bif.rob_Q1_ready = 1'b0; bif.rob_Q2_ready = 1'b0; bif.rob_tail_id = id;
  endtask

  task automatic check_reset_values(input string pfx);
    check_val({pfx, "_empty"}, bif.lsb_empty, 1'b1);
    check_val({pfx, "_full"}, bif.lsb_full, 1'b0);
    check_val({pfx, "_mem_en"}, bif.lsb_mem_enable, 1'b0);
    check_val({pfx, "_mem_op"}, bif.lsb_mem_op, 32'd0);
    check_val({pfx, "_mem_addr"}, bif.lsb_mem_addr, 32'd0);
    check_val({pfx, "_mem_id"}, bif.lsb_mem_id, 32'd0);
    check_val({pfx, "_front_Q1"}, bif.lsb_front_Q1, ND);
    check_val({pfx, "_front_V1"}, bif.lsb_front_V1, 32'd0);
  endtask

  task automatic random_inputs();
    bif.rdy   = ($urandom_range(0, 9) != 0);
    bif.flush = ($urandom_range(0, 39) == 0);
    rst       = ($urandom_range(0, 149) == 0);
    bif.stall = ($urandom_range(0, 4) == 0);
    bif.dec_ready = ($urandom_range(0, 3) != 0);
    bif.dec_op  = 6'($urandom_range(0, 9));
    bif.dec_imm = 32'($urandom_range(0, 24)) - 32'd8;
    case ($urandom_range(0, 3))
      0: bif.rf_val1 = 32'($urandom_range(0, 4095));
      1: bif.rf_val1 = 32'h2fff0 + 32'($urandom_range(0, 31));
      2: bif.rf_val1 = $urandom;
      default: bif.rf_val1 = 32'h30000;
    endcase
    bif.rf_val2 = $urandom;
    bif.rf_dep1 = ($urandom_range(0, 1) != 0) ? ND : 5'($urandom_range(0, 15));
    bif.rf_dep2 = ($urandom_range(0, 1) != 0) ? ND : 5'($urandom_range(0, 15));
    bif.rob_Q1_ready = ($urandom_range(0, 3) == 0); bif.rob_Q1_val = $urandom;
    bif.rob_Q2_ready = ($urandom_range(0, 3) == 0); bif.rob_Q2_val = $urandom;
    bif.rob_tail_id = 4'($urandom_range(0, 15));
    bif.rob_head_id = (mq.size() > 0 && $urandom_range(0, 1) != 0) ? mq[0].id
                                                                    : 4'($urandom_range(0, 15));
    bif.alu_ready = ($urandom_range(0, 1) != 0); bif.alu_res = $urandom;
    bif.alu_id = 4'($urandom_range(0, 15));
    bif.mem_busy = ($urandom_range(0, 2) == 0);
    bif.mem_data_ready = ($urandom_range(0, 1) != 0); bif.mem_data = $urandom;
    bif.mem_id = 4'($urandom_range(0, 15));
    if (bif.mem_id == bif.alu_id) bif.mem_id = bif.mem_id + 4'd1;
  endtask

  initial begin
    set_idle();
    bif.rob_head_id = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_reset_values("reset");

    // Load with no dependencies issues one cycle after reaching the front.
    disp(OP_LW, 32'd4, ND, 32'h100, ND, 32'd0, 4'd5);
    tick();
    set_idle();
    tick();
    check_val("ld_en", bif.lsb_mem_enable, 1'b1);
    check_val("ld_addr", bif.lsb_mem_addr, 32'h104);
    check_val("ld_id", bif.lsb_mem_id, 32'd5);
    check_val("ld_empty", bif.lsb_empty, 1'b1);
    tick();
    check_val("ld_pulse", bif.lsb_mem_enable, 1'b0);

    // I/O load waits until it is the ROB head.
    bif.rob_head_id = 4'd1;
    disp(OP_LB, 32'd0, ND, 32'h30000, ND, 32'd0, 4'd2);
    tick();
    set_idle();
    tick();
    tick();
    check_val("io_hold_en", bif.lsb_mem_enable, 1'b0);
    check_val("io_hold_empty", bif.lsb_empty, 1'b0);
    bif.rob_head_id = 4'd2;
    tick();
    check_val("io_en", bif.lsb_mem_enable, 1'b1);
    check_val("io_addr", bif.lsb_mem_addr, 32'h30000);
    check_val("io_id", bif.lsb_mem_id, 32'd2);

    // Store woken by ALU then memory broadcast, then pops.
    disp(OP_SW, 32'd8, 5'd3, 32'hdead, 5'd5, 32'hbeef, 4'd7);
    tick();
    set_idle();
    bif.alu_ready = 1'b1; bif.alu_id = 4'd3; bif.alu_res = 32'h200;
    tick();
    set_idle();
    bif.mem_data_ready = 1'b1; bif.mem_id = 4'd5; bif.mem_data = 32'hab;
    tick();
    set_idle();
    check_val("st_Q1", bif.lsb_front_Q1, ND);
    check_val("st_Q2", bif.lsb_front_Q2, ND);
    check_val("st_V1", bif.lsb_front_V1, 32'h208);
    check_val("st_V2", bif.lsb_front_V2, 32'hab);
    tick();
    check_val("st_popped", bif.lsb_empty, 1'b1);

    // Fill past capacity while memory is busy, then drain in order across the wrap.
    for (int i = 0; i < 9; i++) begin
      disp(OP_LW, 32'd0, ND, 32'h1000 + 32'(16 * i), ND, 32'd0, 4'(i));
      bif.mem_busy = 1'b1;
      tick();
    end
    check_val("full_set", bif.lsb_full, 1'b1);
    set_idle();
    for (int i = 0; i < 7; i++) begin
      tick();
      check_val("drain_en", bif.lsb_mem_enable, 1'b1);
      check_val("drain_id", bif.lsb_mem_id, 32'(i));
      check_val("drain_addr", bif.lsb_mem_addr, 32'h1000 + 32'(16 * i));
    end
    tick();
    check_val("drain_empty", bif.lsb_empty, 1'b1);

    // Flush with a pending issue cancels it.
    for (int i = 0; i < 4; i++) begin
      disp(OP_LW, 32'd0, ND, 32'h40 + 32'(i), ND, 32'd0, 4'(8 + i));
      bif.mem_busy = 1'b1;
      tick();
    end
    set_idle();
    bif.flush = 1'b1;
    tick();
    check_val("flush_empty", bif.lsb_empty, 1'b1);
    check_val("flush_en", bif.lsb_mem_enable, 1'b0);

    // Reset together with flush restores reset values.
    for (int i = 0; i < 2; i++) begin
      disp(OP_SB, 32'd1, 5'd9, 32'd0, ND, 32'd3, 4'(i));
      tick();
    end
    set_idle();
    rst = 1'b1; bif.flush = 1'b1;
    tick();
    rst = 1'b0; bif.flush = 1'b0;
    check_reset_values("rstflush");

    // Same-cycle ALU broadcast at dispatch is captured.
    disp(OP_SW, 32'd4, 5'd6, 32'h0, ND, 32'h55, 4'd3);
    bif.alu_ready = 1'b1; bif.alu_id = 4'd6; bif.alu_res = 32'h1234;
    tick();
    set_idle();
    check_val("bc_Q1", bif.lsb_front_Q1, ND);
    check_val("bc_V1", bif.lsb_front_V1, 32'h1238);
    check_val("bc_V2", bif.lsb_front_V2, 32'h55);
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      random_inputs();
      tick();
    end
    rst = 1'b0;
    set_idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
